// File: rtl/sum_accum.sv
// Accumulates a fixed number of unsigned adder sums per run and flags overflow.
// Define SUM_ACCUM_SAT_EN to clamp acc on overflow; otherwise acc wraps.
module sum_accum #(
  parameter int N     = 4,
  parameter int CNT_W = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N:0]       s,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic [ACC_W-1:0] acc,
  output logic             acc_valid,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic [ACC_W:0]   s_ext;
  logic [ACC_W:0]   sum_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
    end
  end

  // One extra bit on the adder exposes the carry out of the accumulator.
  always_comb begin
    s_ext      = '0;
    s_ext[N:0] = s;
    sum_full   = {1'b0, acc_reg} + s_ext;
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          acc_next   = '0;
          ovf_next   = 1'b0;
          cnt_next   = len;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (s_valid) begin
          cnt_next = cnt_reg - CNT_W'(1);
          if (sum_full[ACC_W]) begin
            ovf_next = 1'b1;
`ifdef SUM_ACCUM_SAT_EN
            acc_next = '1;
`else
            acc_next = sum_full[ACC_W-1:0];
`endif
          end else begin
            acc_next = sum_full[ACC_W-1:0];
          end
          // A counter loaded with 0 wraps through 2^CNT_W-1 and so runs a full 2^CNT_W samples.
          if (cnt_reg == CNT_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign s_ready   = (state_reg == ACCUM);
  assign busy      = (state_reg != IDLE);
  assign acc_valid = (state_reg == DONE);
  assign acc       = acc_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_sum_accum.sv
// Scoreboard bench for sum_accum: stimulus pushes expected run results, a monitor pops them on acc_valid.
module tb_sum_accum;
  localparam int N       = 4;
  localparam int CNT_W   = 4;
  localparam int ACC_W   = 8;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N:0]       s = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic [ACC_W-1:0] acc;
  logic             acc_valid;
  logic             busy;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int acc;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   smp[$];
  int   gap[$];

  sum_accum #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .s(s), .s_valid(s_valid), .s_ready(s_ready),
    .start(start), .len(len), .acc(acc), .acc_valid(acc_valid),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: the true mathematical total, then folded into ACC_W bits by the overflow policy.
  function automatic int model_acc(input int total);
    if (total > ACC_MAX) begin
`ifdef SUM_ACCUM_SAT_EN
      return ACC_MAX;
`else
      return total % (ACC_MAX + 1);
`endif
    end
    return total;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input int l, input bit keep_start);
    len   = CNT_W'(l);
    start = 1'b1;
    step();
    if (!keep_start) start = 1'b0;
    check("start_busy", busy, 1);
    check("start_acc_clear", acc, 0);
    check("start_ovf_clear", ovf, 0);
    check("start_s_ready", s_ready, 1);
  endtask

  task automatic feed();
    int total = 0;
    for (int i = 0; i < smp.size(); i++) begin
      check("s_ready_accum", s_ready, 1);
      s       = (N+1)'(smp[i]);
      s_valid = 1'b1;
      total  += smp[i];
      if (i == smp.size() - 1)
        exp_q.push_back('{model_acc(total), (total > ACC_MAX) ? 1 : 0});
      step();
      s_valid = 1'b0;
      check("acc_running", acc, model_acc(total));
      check("ovf_running", ovf, (total > ACC_MAX) ? 1 : 0);
      if (i < smp.size() - 1) begin
        check("no_early_done", acc_valid, 0);
        for (int g = 0; g < gap[i]; g++) begin
          s = (N+1)'($urandom_range(0, 31));
          step();
          check("acc_hold_gap", acc, model_acc(total));
          check("s_ready_gap", s_ready, 1);
        end
      end
    end
    check("acc_valid_pulse", acc_valid, 1);
    step();
    check("acc_valid_one_cycle", acc_valid, 0);
    check("idle_busy", busy, 0);
    check("acc_final_hold", acc, model_acc(total));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && acc_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_acc_valid actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        check("final_acc", acc, e.acc);
        check("final_ovf", ovf, e.ovf);
        $display("run done acc=%0d ovf=%0d", acc, ovf);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc", acc, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_acc_valid", acc_valid, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;

    // 5, 31, 0 back-to-back; start on the first edge after reset release
    smp = '{5, 31, 0};
    gap = '{0, 0, 0};
    begin_run(3, 1'b0);
    feed();

    // idle gap between samples
    smp = '{10, 20};
    gap = '{3, 0};
    begin_run(2, 1'b0);
    feed();

    // len=0 gives sixteen samples; extra s_valid in IDLE ignored
    smp.delete();
    gap.delete();
    for (int i = 0; i < 16; i++) begin
      smp.push_back(1);
      gap.push_back(0);
    end
    begin_run(0, 1'b0);
    feed();
    s       = 5'd9;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_ignore_acc", acc, 16);
      check("idle_s_ready", s_ready, 0);
      check("idle_busy_hold", busy, 0);
    end
    s_valid = 1'b0;

    // overflow: sixteen samples of 31
    smp.delete();
    gap.delete();
    for (int i = 0; i < 16; i++) begin
      smp.push_back(31);
      gap.push_back(0);
    end
    begin_run(0, 1'b0);
    feed();

    // reset in the middle of a run
    begin_run(4, 1'b0);
    s = 5'd3; s_valid = 1'b1;
    step();
    s = 5'd4;
    step();
    s_valid = 1'b0;
    check("midrun_acc", acc, 7);
    rst = 1'b1;
    #1;
    check("async_rst_acc", acc, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_s_ready", s_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_no_acc_valid", acc_valid, 0);
    end
    rst = 1'b0;
    smp = '{7};
    gap = '{0};
    begin_run(1, 1'b0);
    feed();

    // start held high for a whole run, then a second run begins from IDLE
    smp = '{12, 9};
    gap = '{0, 0};
    begin_run(2, 1'b1);
    feed();
    step();
    check("restart_busy", busy, 1);
    check("restart_acc_clear", acc, 0);
    start = 1'b0;
    smp = '{4, 6};
    feed();

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      int l;
      int n;
      l = $urandom_range(0, 15);
      n = (l == 0) ? 16 : l;
      smp.delete();
      gap.delete();
      for (int i = 0; i < n; i++) begin
        smp.push_back($urandom_range(0, 31));
        gap.push_back($urandom_range(0, 2));
      end
      begin_run(l, 1'b0);
      feed();
    end

    step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_accum.md
SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the adder operand width; input sum width is N+1.
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the sample-count field.
REQ-003 The block SHALL have parameter ACC_W, default 12, giving the accumulator width; ACC_W >= N+1.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port s, input, N+1 bits, the unsigned sum from the upstream adder (carry in MSB).
REQ-007 The block SHALL have port s_valid, input, 1 bit, meaning s holds a sample.
REQ-008 The block SHALL have port s_ready, output, 1 bit, meaning the block accepts a sample this cycle.
REQ-009 The block SHALL have port start, input, 1 bit, which requests a new accumulation run.
REQ-010 The block SHALL have port len, input, CNT_W bits, giving the samples per run; 0 means 2^CNT_W samples.
REQ-011 The block SHALL have port acc, output, ACC_W bits, the running or final total.
REQ-012 The block SHALL have port acc_valid, output, 1 bit, a one-cycle pulse marking acc as final.
REQ-013 The block SHALL have port busy, output, 1 bit, high in states ACCUM and DONE.
REQ-014 The block SHALL have port ovf, output, 1 bit, a sticky overflow flag for the current run.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM and DONE, and all outputs SHALL be registered or decoded from state only.
REQ-016 In IDLE, with start=1, the block SHALL clear acc to 0, clear ovf, load the counter with len and go to ACCUM at the next edge.
REQ-017 In IDLE, s_ready SHALL be 0 and samples SHALL be ignored.
REQ-018 In ACCUM, s_ready SHALL be 1.
REQ-019 A sample SHALL be accepted on an edge only when s_valid=1 and s_ready=1, giving acc <= acc + zero-extend(s) and counter <= counter-1 (modulo 2^CNT_W).
REQ-020 When the counter equals 1 at an accepting edge, the block SHALL go to DONE; loading len=0 therefore yields exactly 2^CNT_W samples.
REQ-021 The block SHALL hold acc, counter and state in ACCUM when s_valid=0, with no timeout.
REQ-022 In DONE, acc_valid SHALL be 1 for exactly one cycle, the cycle immediately after the last accepting edge, and the FSM SHALL then return to IDLE.
REQ-023 acc SHALL keep its final value until the next accepted start.
REQ-024 start SHALL be ignored in ACCUM and DONE; start in the first IDLE cycle after DONE SHALL be honoured.
REQ-025 If the true sum exceeds 2^ACC_W-1 on any add, ovf SHALL be set and stay set until the next start or reset; the acc result follows REQ-030.

Reset
REQ-026 Asserting rst at any time SHALL immediately force state IDLE, acc=0, counter=0, ovf=0, acc_valid=0, s_ready=0 and busy=0.
REQ-027 A run interrupted by reset SHALL be abandoned, and no acc_valid SHALL follow.
REQ-028 On the first edge after rst deasserts, the block SHALL behave as IDLE, and a start sampled on that edge SHALL be honoured.

Configuration
REQ-029 Macro SUM_ACCUM_SAT_EN SHALL select overflow handling at compile time.
REQ-030 With SUM_ACCUM_SAT_EN defined, an overflowing add SHALL clamp acc to 2^ACC_W-1 and hold it there for the rest of the run; without it, acc SHALL wrap modulo 2^ACC_W. ovf behaviour SHALL be identical in both builds.

Verification
REQ-031 Scenario: N=4, len=3, start, then samples s=5, 31, 0 back-to-back -> acc=36, acc_valid pulses once one cycle after the third accept, ovf=0.
REQ-032 Scenario: len=2 with s_valid gaps of 3 idle cycles between samples 10 and 20 -> s_ready stays 1, acc holds 10 across the gap, final acc=30.
REQ-033 Scenario: len=0 (CNT_W=4) with sixteen samples of 1 -> exactly 16 accepts, acc=16, and a 17th s_valid in IDLE is ignored.
REQ-034 Scenario: ACC_W=8, len=0, sixteen samples of 31 -> wrap build gives acc=240, ovf=1; SUM_ACCUM_SAT_EN build gives acc=255, ovf=1.
REQ-035 Scenario: rst asserted mid-run after 2 of 4 samples -> acc=0 and busy=0 immediately, no acc_valid; a new start with len=1 and s=7 gives acc=7.
REQ-036 Scenario: start held high through a whole run -> exactly one run per IDLE entry, and start in ACCUM/DONE does not clear acc.
